// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The requester drives the master side and the divider implements the slave side.
interface seq_divider_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, signed or unsigned per operation.
// Operands are divided as magnitudes; the result signs are applied in a final fix-up cycle.
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    logic             divisor_zero_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   next_rem_s;
    logic             q_bit_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    // Two's complement negation when neg is set; |MIN_INT| comes out as 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    assign divisor_zero_s = (bus.divisor == {WIDTH{1'b0}});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a zero divisor skips the iteration entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (divisor_zero_s) begin
                        state_s = FIX;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(1)) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One restoring step: quo_r shifts dividend bits out of its MSB and quotient bits into its LSB.
    always_comb begin
        shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
        if (diff_s[WIDTH]) begin
            next_rem_s = shift_s;
            q_bit_s    = 1'b0;
        end else begin
            next_rem_s = diff_s;
            q_bit_s    = 1'b1;
        end
        q_fix_s = cond_neg(quo_r, neg_q_r);
        r_fix_s = cond_neg(rem_r[WIDTH-1:0], neg_r_r);
    end

    // Operand capture, iteration and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r         <= {CW{1'b0}};
            rem_r         <= {(WIDTH+1){1'b0}};
            quo_r         <= {WIDTH{1'b0}};
            dvs_r         <= {WIDTH{1'b0}};
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            dbz_r         <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        cnt_r  <= CW'(WIDTH);
                        dvs_r  <= cond_neg(bus.divisor, bus.is_signed & bus.divisor[WIDTH-1]);
                        if (divisor_zero_s) begin
                            // Remainder is the raw dividend, so no sign fix-up is wanted.
                            quo_r   <= {WIDTH{1'b0}};
                            rem_r   <= {1'b0, bus.dividend};
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            dbz_r   <= 1'b1;
                        end else begin
                            quo_r   <= cond_neg(bus.dividend, bus.is_signed & bus.dividend[WIDTH-1]);
                            rem_r   <= {(WIDTH+1){1'b0}};
                            neg_q_r <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            neg_r_r <= bus.is_signed & bus.dividend[WIDTH-1];
                            dbz_r   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= next_rem_s;
                    quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
                    cnt_r <= cnt_r - CW'(1);
                end
                FIX: begin
                    quotient_r    <= q_fix_s;
                    remainder_r   <= r_fix_s;
                    div_by_zero_r <= dbz_r;
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 64-bit and 8-bit instances checked every cycle against an arithmetic model,
// with hand-computed literal results pinning the model on each directed vector.
module tb_seq_divider;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   timeouts = 0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int          lat;
        int          start;
        bit          pin;
        logic [63:0] pq;
        logic [63:0] pr;
        logic        pdz;
    } exp_t;

    exp_t        fifo[2][$];
    logic [63:0] hold_q[2];
    logic [63:0] hold_r[2];
    logic        hold_dz[2];

    seq_divider_if #(.WIDTH(64)) b64 ();
    seq_divider_if #(.WIDTH(8))  b8 ();

    seq_divider #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(b64));
    seq_divider #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Division rules on magnitudes: truncate toward zero, remainder follows dividend sign.
    function automatic void model(input int w, input bit sgn, input logic [63:0] a_in,
                                  input logic [63:0] b_in, output logic [63:0] q,
                                  output logic [63:0] r, output logic dz);
        logic [63:0] mask, a, b, ma, mb;
        bit sa, sb;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (b == 64'd0) begin
            q = 64'd0; r = a; dz = 1'b1;
        end else begin
            sa = sgn && a[w-1];
            sb = sgn && b[w-1];
            ma = sa ? ((-a) & mask) : a;
            mb = sb ? ((-b) & mask) : b;
            q  = ma / mb;
            r  = ma % mb;
            if (sa ^ sb) q = (-q) & mask;
            if (sa)      r = (-r) & mask;
            dz = 1'b0;
        end
    endfunction

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (dut%0d, cycle %0d): got %h, required %h", name, d, cyc, act, req);
        end
    endtask

    // Single compare process: handshake, latency, results and output stability on every cycle.
    always @(negedge clk) begin : compare
        exp_t        e;
        logic        bsy, dn, dz;
        logic [63:0] qq, rr;
        bit          exp_busy;
        for (int d = 0; d < 2; d++) begin
            bsy = (d == 0) ? b64.busy        : b8.busy;
            dn  = (d == 0) ? b64.done        : b8.done;
            dz  = (d == 0) ? b64.div_by_zero : b8.div_by_zero;
            qq  = (d == 0) ? b64.quotient    : {56'd0, b8.quotient};
            rr  = (d == 0) ? b64.remainder   : {56'd0, b8.remainder};
            if (reset) begin
                check("reset_busy", d, {63'd0, bsy}, 64'd0);
                check("reset_done", d, {63'd0, dn}, 64'd0);
                check("reset_dbz", d, {63'd0, dz}, 64'd0);
                check("reset_q", d, qq, 64'd0);
                check("reset_r", d, rr, 64'd0);
                fifo[d].delete();
                hold_q[d] = 64'd0; hold_r[d] = 64'd0; hold_dz[d] = 1'b0;
            end else if (dn) begin
                check("busy_with_done", d, {63'd0, bsy}, 64'd0);
                if (fifo[d].size() == 0) begin
                    check("unexpected_done", d, 64'd1, 64'd0);
                end else begin
                    e = fifo[d].pop_front();
                    check("latency", d, 64'(cyc - e.start), 64'(e.lat));
                    check("quotient", d, qq, e.q);
                    check("remainder", d, rr, e.r);
                    check("div_by_zero", d, {63'd0, dz}, {63'd0, e.dz});
                    if (e.pin) begin
                        check("model_q", d, e.q, e.pq);
                        check("model_r", d, e.r, e.pr);
                        check("lit_q", d, qq, e.pq);
                        check("lit_r", d, rr, e.pr);
                        check("lit_dbz", d, {63'd0, dz}, {63'd0, e.pdz});
                    end
                    hold_q[d] = e.q; hold_r[d] = e.r; hold_dz[d] = e.dz;
                end
            end else begin
                exp_busy = (fifo[d].size() > 0) && (cyc >= fifo[d][0].start);
                check("busy", d, {63'd0, bsy}, {63'd0, exp_busy});
                check("hold_q", d, qq, hold_q[d]);
                check("hold_r", d, rr, hold_r[d]);
                check("hold_dbz", d, {63'd0, dz}, {63'd0, hold_dz[d]});
            end
        end
        check("no_timeout", 0, 64'(timeouts), 64'd0);
    end

    // Called at a negedge: drives start for exactly one rising edge, then scrambles the operands.
    task automatic issue(input int d, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                         input bit pin, input logic [63:0] pq, input logic [63:0] pr, input logic pdz);
        exp_t e;
        int   w;
        w = (d == 0) ? 64 : 8;
        model(w, sgn, a, b, e.q, e.r, e.dz);
        e.lat = e.dz ? 1 : w + 1;
        e.start = cyc + 1;
        e.pin = pin; e.pq = pq; e.pr = pr; e.pdz = pdz;
        fifo[d].push_back(e);
        if (d == 0) begin
            b64.start = 1'b1; b64.is_signed = sgn; b64.dividend = a; b64.divisor = b;
        end else begin
            b8.start = 1'b1; b8.is_signed = sgn; b8.dividend = a[7:0]; b8.divisor = b[7:0];
        end
        @(negedge clk);
        if (d == 0) begin
            b64.start = 1'b0; b64.is_signed = ~sgn;
            b64.dividend = 64'hDEAD_BEEF_0BAD_F00D; b64.divisor = 64'd0;
        end else begin
            b8.start = 1'b0; b8.is_signed = ~sgn; b8.dividend = 8'hA5; b8.divisor = 8'd0;
        end
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (!((d == 0) ? b64.done : b8.done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeouts++;
    endtask

    initial begin
        b64.start = 1'b0; b64.is_signed = 1'b0; b64.dividend = 64'd0; b64.divisor = 64'd0;
        b8.start = 1'b0;  b8.is_signed = 1'b0;  b8.dividend = 8'd0;   b8.divisor = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 1'b0, 64'd57, 64'd8, 1'b1, 64'd7, 64'd1, 1'b0);
        wait_done(0);
        issue(0, 1'b1, -64'd57, 64'd8, 1'b1, -64'd7, -64'd1, 1'b0);
        wait_done(0);
        issue(0, 1'b1, 64'd57, -64'd8, 1'b1, -64'd7, 64'd1, 1'b0);
        wait_done(0);
        issue(0, 1'b1, -64'd57, -64'd8, 1'b1, 64'd7, -64'd1, 1'b0);
        wait_done(0);

        issue(0, 1'b0, 64'd57, 64'd0, 1'b1, 64'd0, 64'd57, 1'b1);
        wait_done(0);
        issue(0, 1'b1, 64'd57, 64'd0, 1'b1, 64'd0, 64'd57, 1'b1);
        wait_done(0);
        issue(0, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 1'b0);
        wait_done(0);
        issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h8000_0000_0000_0000, 64'd0, 1'b0);
        wait_done(0);

        issue(1, 1'b0, 64'd255, 64'd1, 1'b1, 64'd255, 64'd0, 1'b0);
        wait_done(1);
        issue(1, 1'b1, 64'h80, 64'hFF, 1'b1, 64'h80, 64'd0, 1'b0);
        wait_done(1);
        issue(1, 1'b0, 64'd5, 64'd200, 1'b1, 64'd0, 64'd5, 1'b0);
        wait_done(1);
        issue(1, 1'b1, -64'd100, 64'd7, 1'b1, 64'hF2, 64'hFE, 1'b0);
        wait_done(1);

        // start re-asserted mid-operation must be ignored
        issue(0, 1'b0, 64'd57, 64'd8, 1'b1, 64'd7, 64'd1, 1'b0);
        repeat (30) @(negedge clk);
        b64.start = 1'b1; b64.is_signed = 1'b0; b64.dividend = 64'd100; b64.divisor = 64'd10;
        @(negedge clk);
        b64.start = 1'b0;
        wait_done(0);
        repeat (10) @(negedge clk);

        // asynchronous reset in the middle of a divide
        issue(0, 1'b0, 64'd12345, 64'd7, 1'b1, 64'd1763, 64'd4, 1'b0);
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, 64'd57, 64'd8, 1'b1, 64'd7, 64'd1, 1'b0);
        wait_done(0);

        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
